// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer serving DEPTH 8-bit registers with programmable wait states
// Ports: clk, rst (async, active high); psel/penable/pwrite/paddr/pwdata from the bridge;
//        prdata/pready/pslverr transfer response; proto_err sticky bridge-sequencing flag.
module apb_slave_regfile #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    output logic       proto_err
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [7:0] addr_q, wdata_q;
    logic       write_q, load, we, perr_set, valid;
    logic [7:0] mem [DEPTH];

    // Range check on all 8 address bits so high addresses never alias into memory.
    assign valid   = {24'd0, addr_q} < 32'(DEPTH);
    assign pready  = state == ACCESS && cnt == 4'd0;
    assign pslverr = pready && !valid;
    assign prdata  = pready && !write_q && valid ? mem[addr_q[AW-1:0]] : 8'h00;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load     = 1'b0;
        we       = 1'b0;
        perr_set = 1'b0;
        if (state == IDLE) begin
            if (psel && !penable) begin
                state_nx = ACCESS;
                cnt_nx   = 4'(WAIT_CYCLES);
                load     = 1'b1;
            end else if (psel && penable) begin
                perr_set = 1'b1;
            end
        end else if (!(psel && penable)) begin
            // Bridge dropped the access phase before completion: abort without writing.
            state_nx = IDLE;
            perr_set = 1'b1;
        end else if (cnt != 4'd0) begin
            cnt_nx = cnt - 4'd1;
        end else begin
            state_nx = IDLE;
            we       = write_q && valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            write_q   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            proto_err <= proto_err | perr_set;
            if (load) begin
                addr_q  <= paddr;
                wdata_q <= pwdata;
                write_q <= pwrite;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (we) begin
            mem[addr_q[AW-1:0]] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: randomized and directed checks of two regfile instances (WAIT_CYCLES 0 and 1)
module tb_apb_slave_regfile;
    logic       clk = 1'b0;
    logic [1:0] rst = 2'b11;
    logic [1:0] psel = 2'b00, penable = 2'b00, pwrite = 2'b00;
    logic [7:0] paddr [2] = '{8'h00, 8'h00};
    logic [7:0] pwdata[2] = '{8'h00, 8'h00};
    logic [7:0] prdata[2];
    logic [1:0] pready, pslverr, proto_err;

    int tests = 0;
    int fails = 0;
    int wc[2] = '{0, 1};

    logic [7:0] mem_m [2][16];
    logic       perr_m[2];

    always #5 clk = ~clk;

    apb_slave_regfile #(.DEPTH(16), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst[0]), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0]), .proto_err(proto_err[0])
    );

    apb_slave_regfile #(.DEPTH(16), .WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst[1]), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1]), .proto_err(proto_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        for (int i = 0; i < 16; i++) mem_m[d][i] = 8'h00;
        perr_m[d] = 1'b0;
    endtask

    // Full setup+access transfer starting at a negedge; bus inputs are scrambled during
    // the access phase since the completer must use the values captured at setup.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd);
        logic [7:0] er;
        bit         in_range;
        in_range = a < 8'd16;
        er = (!wr && in_range) ? mem_m[d][a[3:0]] : 8'h00;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
        @(negedge clk);
        penable[d] = 1'b1;
        for (int i = 0; i <= wc[d]; i++) begin
            pwrite[d] = 1'($urandom); paddr[d] = 8'($urandom); pwdata[d] = 8'($urandom);
            #1;
            chk($sformatf("d%0d a%0h c%0d pready", d, a, i), 32'(pready[d]), 32'(i == wc[d]));
            if (i == wc[d]) begin
                chk($sformatf("d%0d a%0h pslverr", d, a), 32'(pslverr[d]), 32'(!in_range));
                chk($sformatf("d%0d a%0h prdata", d, a), 32'(prdata[d]), 32'(er));
            end
            @(negedge clk);
        end
        psel[d] = 1'b0; penable[d] = 1'b0;
        if (wr && in_range) mem_m[d][a[3:0]] = wd;
        chk($sformatf("d%0d a%0h proto_err", d, a), 32'(proto_err[d]), 32'(perr_m[d]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset(0);
        model_reset(1);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d reset pready", d), 32'(pready[d]), 32'd0);
            chk($sformatf("d%0d reset pslverr", d), 32'(pslverr[d]), 32'd0);
            chk($sformatf("d%0d reset prdata", d), 32'(prdata[d]), 32'd0);
            chk($sformatf("d%0d reset proto_err", d), 32'(proto_err[d]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 2'b00;

        xfer(1, 1, 8'h05, 8'h3C);
        xfer(1, 0, 8'h05, 8'h00);
        xfer(1, 1, 8'h20, 8'hAA);
        xfer(1, 0, 8'h20, 8'h00);

        xfer(0, 1, 8'h00, 8'h11);
        xfer(0, 1, 8'h01, 8'h22);
        xfer(0, 1, 8'h02, 8'h33);
        xfer(0, 0, 8'h00, 8'h00);
        xfer(0, 0, 8'h01, 8'h00);
        xfer(0, 0, 8'h02, 8'h00);

        for (int n = 0; n < 40; n++) begin
            for (int d = 0; d < 2; d++) begin
                logic [7:0] a;
                a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
                xfer(d, 1'($urandom), a, 8'($urandom));
            end
        end

        // Abort on the WAIT_CYCLES=1 instance: psel drops during the wait state.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h03; pwdata[1] = 8'h55;
        @(negedge clk);
        penable[1] = 1'b1;
        #1;
        chk("abort wait pready", 32'(pready[1]), 32'd0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        #1;
        perr_m[1] = 1'b1;
        chk("abort proto_err", 32'(proto_err[1]), 32'd1);
        chk("abort pready", 32'(pready[1]), 32'd0);
        @(negedge clk);
        xfer(1, 0, 8'h03, 8'h00);

        // Reset while the wait counter is nonzero on a pending write.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h04; pwdata[1] = 8'h77;
        @(negedge clk);
        penable[1] = 1'b1;
        #1 rst[1] = 1'b1;
        #1;
        chk("rst1 pready", 32'(pready[1]), 32'd0);
        chk("rst1 pslverr", 32'(pslverr[1]), 32'd0);
        chk("rst1 prdata", 32'(prdata[1]), 32'd0);
        chk("rst1 proto_err", 32'(proto_err[1]), 32'd0);
        @(negedge clk);
        rst[1] = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
        model_reset(1);
        xfer(1, 0, 8'h04, 8'h00);

        // Reset while a read is completing: response must drop without waiting for a clock.
        xfer(0, 1, 8'h09, 8'h5A);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'h09;
        @(negedge clk);
        penable[0] = 1'b1;
        #1;
        chk("rst0 pre pready", 32'(pready[0]), 32'd1);
        chk("rst0 pre prdata", 32'(prdata[0]), 32'h5A);
        rst[0] = 1'b1;
        #1;
        chk("rst0 pready", 32'(pready[0]), 32'd0);
        chk("rst0 prdata", 32'(prdata[0]), 32'd0);
        @(negedge clk);
        rst[0] = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
        model_reset(0);
        xfer(0, 0, 8'h09, 8'h00);
        xfer(0, 1, 8'h0F, 8'hC3);

        // Stray enable in IDLE with no setup phase.
        psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 8'h06; pwdata[1] = 8'hEE;
        @(negedge clk);
        psel[1] = 1'b0; penable[1] = 1'b0;
        #1;
        perr_m[1] = 1'b1;
        chk("stray proto_err", 32'(proto_err[1]), 32'd1);
        chk("stray pready", 32'(pready[1]), 32'd0);
        @(negedge clk);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) xfer(d, 0, 8'(i), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
